// File: rtl/gray_pkg.sv
// rtl/gray_pkg.sv - shared state type and Gray/binary conversion helpers
package gray_pkg;

  // Helpers operate on a fixed wide word; callers zero-extend and truncate with size casts.
  localparam int GRAY_MAX_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } gray_state_e;

  function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Prefix XOR from the MSB down; zero-extended upper bits leave the result unaffected.
  function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
    logic [GRAY_MAX_W-1:0] b;
    b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
    for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_sequence_gen.sv
// rtl/gray_sequence_gen.sv - programmable-length Gray/binary code word source on a valid/ready stream
module gray_sequence_gen
  import gray_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH:0]   len,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_gray,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] gray_out,
  output logic [WIDTH-1:0] bin_out,
  output logic             wrap,
  output logic             done
);

  gray_state_e      r_state;
  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH:0]   r_rem;
  logic             r_dir;
  logic             w_hs;

  assign out_valid = (r_state == ST_RUN);
  assign done      = (r_state == ST_DONE);
  assign bin_out   = r_cnt;
  assign gray_out  = WIDTH'(bin2gray(GRAY_MAX_W'(r_cnt)));
  assign w_hs      = out_valid & out_ready;
  assign wrap      = w_hs & (r_dir ? (r_cnt == '1) : (r_cnt == '0));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_rem   <= '0;
      r_dir   <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          // A simultaneous load seeds the counter that the new run starts from.
          if (load) begin
            r_cnt <= WIDTH'(gray2bin(GRAY_MAX_W'(load_gray)));
          end
          if (start) begin
            if (len != '0) begin
              r_state <= ST_RUN;
              r_rem   <= len;
              r_dir   <= up;
            end else begin
              r_state <= ST_DONE;
            end
          end
        end
        ST_RUN: begin
          if (w_hs) begin
            r_cnt <= r_dir ? (r_cnt + WIDTH'(1)) : (r_cnt - WIDTH'(1));
            r_rem <= r_rem - (WIDTH+1)'(1);
            if (r_rem == (WIDTH+1)'(1)) begin
              r_state <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gray_sequence_gen.sv
// tb/tb_gray_sequence_gen.sv - directed self-checking bench for gray_sequence_gen (WIDTH=4)
module tb_gray_sequence_gen;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W:0]   len;
  logic         up;
  logic         load;
  logic [W-1:0] load_gray;
  logic         out_ready;
  logic         out_valid;
  logic [W-1:0] gray_out;
  logic [W-1:0] bin_out;
  logic         wrap;
  logic         done;

  int n_cmp = 0;
  int n_err = 0;

  gray_sequence_gen #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .len       (len),
    .up        (up),
    .load      (load),
    .load_gray (load_gray),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .gray_out  (gray_out),
    .bin_out   (bin_out),
    .wrap      (wrap),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are checked 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  logic [3:0] exp_up5 [5];
  int words;
  int wraps;

  initial begin
    exp_up5[0] = 4'b0000;
    exp_up5[1] = 4'b0001;
    exp_up5[2] = 4'b0011;
    exp_up5[3] = 4'b0010;
    exp_up5[4] = 4'b0110;

    // Reset with random inputs
    rst = 1'b1;
    start = 1'($urandom); len = 5'($urandom); up = 1'($urandom);
    load = 1'($urandom); load_gray = 4'($urandom); out_ready = 1'($urandom);
    tick();
    start = 1'($urandom); len = 5'($urandom); load = 1'($urandom);
    load_gray = 4'($urandom); out_ready = 1'($urandom);
    tick();
    rst = 1'b0; start = 1'b0; load = 1'b0; len = '0; up = 1'b1; load_gray = '0; out_ready = 1'b0;
    settle();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_gray",  32'(gray_out),  32'd0);
    chk("rst_bin",   32'(bin_out),   32'd0);
    chk("rst_wrap",  32'(wrap),      32'd0);
    chk("rst_done",  32'(done),      32'd0);

    // Run up from 0, len=5
    start = 1'b1; len = 5'd5; up = 1'b1; out_ready = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      settle();
      chk("up5_valid", 32'(out_valid), 32'd1);
      chk("up5_gray",  32'(gray_out),  32'(exp_up5[i]));
      chk("up5_wrap",  32'(wrap),      32'd0);
      tick();
    end
    chk("up5_done",    32'(done),      32'd1);
    chk("up5_dvalid",  32'(out_valid), 32'd0);
    chk("up5_bin_end", 32'(bin_out),   32'd5);
    chk("up5_gray_end",32'(gray_out),  32'b0111);
    tick();
    chk("up5_done_clr", 32'(done), 32'd0);

    // Backpressure, with load+start together and start/load ignored mid-run
    load = 1'b1; load_gray = 4'b0000; start = 1'b1; len = 5'd5; up = 1'b1; out_ready = 1'b1;
    tick();
    load = 1'b0; start = 1'b0;
    chk("bp_w0", 32'(gray_out), 32'b0000);
    tick();
    chk("bp_w1", 32'(gray_out), 32'b0001);
    tick();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i == 1) begin
        start = 1'b1; load = 1'b1; load_gray = 4'b1111; len = 5'd0; up = 1'b0;
      end
      settle();
      chk("bp_hold_valid", 32'(out_valid), 32'd1);
      chk("bp_hold_gray",  32'(gray_out),  32'b0011);
      tick();
      start = 1'b0; load = 1'b0;
    end
    out_ready = 1'b1;
    settle();
    chk("bp_w2", 32'(gray_out), 32'b0011);
    tick();
    chk("bp_w3", 32'(gray_out), 32'b0010);
    tick();
    chk("bp_w4", 32'(gray_out), 32'b0110);
    tick();
    chk("bp_done", 32'(done),    32'd1);
    chk("bp_bin",  32'(bin_out), 32'd5);
    tick();

    // Preload 1000 (bin 1111) then up-wrap run of 2
    load = 1'b1; load_gray = 4'b1000;
    tick();
    load = 1'b0;
    chk("pl_bin",   32'(bin_out),   32'b1111);
    chk("pl_valid", 32'(out_valid), 32'd0);
    start = 1'b1; len = 5'd2; up = 1'b1; out_ready = 1'b1;
    tick();
    start = 1'b0;
    settle();
    chk("upw_g0",    32'(gray_out), 32'b1000);
    chk("upw_wrap0", 32'(wrap),     32'd1);
    tick();
    settle();
    chk("upw_g1",    32'(gray_out), 32'b0000);
    chk("upw_wrap1", 32'(wrap),     32'd0);
    tick();
    chk("upw_done", 32'(done),    32'd1);
    chk("upw_bin",  32'(bin_out), 32'b0001);
    tick();

    // Down-wrap from 0
    load = 1'b1; load_gray = 4'b0000; start = 1'b1; len = 5'd2; up = 1'b0;
    tick();
    load = 1'b0; start = 1'b0; up = 1'b1;
    settle();
    chk("dnw_g0",    32'(gray_out), 32'b0000);
    chk("dnw_wrap0", 32'(wrap),     32'd1);
    tick();
    settle();
    chk("dnw_g1",    32'(gray_out), 32'b1000);
    chk("dnw_b1",    32'(bin_out),  32'b1111);
    chk("dnw_wrap1", 32'(wrap),     32'd0);
    chk("dnw_nodone",32'(done),     32'd0);
    tick();
    chk("dnw_done", 32'(done),    32'd1);
    chk("dnw_bin",  32'(bin_out), 32'b1110);
    tick();
    chk("dnw_done_clr", 32'(done), 32'd0);

    // len=0: done at t+1, no word
    start = 1'b1; len = 5'd0;
    tick();
    start = 1'b0;
    chk("len0_done",  32'(done),      32'd1);
    chk("len0_valid", 32'(out_valid), 32'd0);
    tick();
    chk("len0_done_clr", 32'(done),      32'd0);
    chk("len0_valid2",   32'(out_valid), 32'd0);

    // Full-length run from 0 up: 16 words, single wrap on the final handshake
    load = 1'b1; load_gray = 4'b0000; start = 1'b1; len = 5'd16; up = 1'b1; out_ready = 1'b1;
    tick();
    load = 1'b0; start = 1'b0;
    words = 0; wraps = 0;
    for (int c = 0; c < 20; c++) begin
      settle();
      if (out_valid) begin
        if (wrap) begin
          wraps++;
          chk("full_wrap_last", 32'(words), 32'd15);
        end
        words++;
      end
      if (done) break;
      tick();
    end
    chk("full_done",  32'(done),    32'd1);
    chk("full_words", 32'(words),   32'd16);
    chk("full_wraps", 32'(wraps),   32'd1);
    chk("full_bin",   32'(bin_out), 32'd0);
    tick();

    // Reset mid-run after 2 words
    start = 1'b1; len = 5'd5; up = 1'b1; out_ready = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    chk("mr_pre_bin", 32'(bin_out), 32'd2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mr_valid", 32'(out_valid), 32'd0);
    chk("mr_bin",   32'(bin_out),   32'd0);
    chk("mr_done",  32'(done),      32'd0);
    tick();
    chk("mr_done2",  32'(done),      32'd0);
    chk("mr_valid2", 32'(out_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
